// File: rtl/mod_reduce512.sv
// Bit-serial modular reduction: result = datain mod modn.
// One product bit per cycle, MSB first, single conditional subtract.
module mod_reduce512 #(
    parameter int PW = 512,
    parameter int MW = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          update,
    input  logic [PW-1:0] datain,
    input  logic [MW-1:0] modn,
    output logic [MW-1:0] result,
    output logic          done,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(PW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t        r_state;
    logic          r_update_d;
    logic [PW-1:0] r_data;
    logic [MW-1:0] r_mod;
    logic [MW:0]   r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_zero;

    logic          w_start;
    logic [MW:0]   w_t;
    logic [MW:0]   w_n;
    logic          w_ge;
    logic [MW:0]   w_next;

    assign w_start = update & ~r_update_d;
    assign w_t     = {r_rem[MW-1:0], r_data[PW-1]};
    assign w_n     = {1'b0, r_mod};
    // r < n keeps the top bit of r clear; it only guards the compare
    assign w_ge    = r_rem[MW] | (w_t >= w_n);
    assign w_next  = w_ge ? (w_t - w_n) : w_t;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_update_d <= 1'b0;
            r_data     <= '0;
            r_mod      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_zero     <= 1'b0;
            result     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_update_d <= update;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_data <= datain;
                        r_mod  <= modn;
                        r_rem  <= '0;
                        r_cnt  <= CW'(PW - 1);
                        done   <= 1'b0;
                        err    <= 1'b0;
                        if (modn == '0) begin
                            r_zero  <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_zero  <= 1'b0;
                            busy    <= 1'b1;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem  <= w_next;
                    r_data <= r_data << 1;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        result  <= w_next[MW-1:0];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    // zero modulus reports its error one edge after capture
                    if (r_zero) begin
                        err    <= 1'b1;
                        result <= '0;
                        done   <= 1'b1;
                        r_zero <= 1'b0;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce512.sv
// Directed self-checking bench for mod_reduce512.
module tb_mod_reduce512;

    localparam int PW = 512;
    localparam int MW = 256;

    logic          clk;
    logic          rst;
    logic          update;
    logic [PW-1:0] datain;
    logic [MW-1:0] modn;
    logic [MW-1:0] result;
    logic          done;
    logic          busy;
    logic          err;

    int total;
    int bad;

    mod_reduce512 #(.PW(PW), .MW(MW)) dut (
        .clk    (clk),
        .rst    (rst),
        .update (update),
        .datain (datain),
        .modn   (modn),
        .result (result),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [PW-1:0] d, input logic [MW-1:0] m);
        @(negedge clk);
        datain = d;
        modn   = m;
        update = 1'b1;
        @(posedge clk);
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_done(output int edges, output logic busy_pre,
                             output logic busy_any);
        edges    = 0;
        busy_pre = 1'b0;
        busy_any = busy;
        for (int k = 1; k <= 700; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_any = 1'b1;
            if (k == PW - 1) busy_pre = busy;
            if (done) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int   e;
        logic bp, ba;
        rst    = 1'b1;
        update = 1'b0;
        datain = PW'(100);
        modn   = MW'(7);
        @(posedge clk);
        @(negedge clk);
        update = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (result !== '0) begin
            bad++;
            $display("FAIL reset_result got=%0h want=0", result);
        end
        total++;
        if ({done, busy, err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000", {done, busy, err});
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        update = 1'b0;
        wait_done(e, bp, ba);
        total++;
        if (e !== PW) begin
            bad++;
            $display("FAIL held_update_latency got=%0d want=%0d", e, PW);
        end
        total++;
        if (result !== MW'(2)) begin
            bad++;
            $display("FAIL held_update_result got=%0d want=2", result);
        end
    endtask

    task automatic test_basic();
        int   e;
        logic bp, ba;
        start_op(PW'(100), MW'(7));
        wait_done(e, bp, ba);
        total++;
        if (e !== PW) begin
            bad++;
            $display("FAIL basic_latency got=%0d want=%0d", e, PW);
        end
        total++;
        if (result !== MW'(2)) begin
            bad++;
            $display("FAIL basic_result got=%0d want=2", result);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL basic_err got=%b want=0", err);
        end
        total++;
        if (bp !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy_e511 got=%b want=1", bp);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_e512 got=%b want=0", busy);
        end
        repeat (5) @(negedge clk);
        total++;
        if ({done, result} !== {1'b1, MW'(2)}) begin
            bad++;
            $display("FAIL basic_hold got=%b/%0d want=1/2", done, result);
        end
    endtask

    task automatic run_vec(input string nm, input logic [PW-1:0] d,
                           input logic [MW-1:0] m, input logic [MW-1:0] want);
        int   e;
        logic bp, ba;
        start_op(d, m);
        wait_done(e, bp, ba);
        total++;
        if (e !== PW || result !== want) begin
            bad++;
            $display("FAIL %s got=%0h lat=%0d want=%0h lat=%0d",
                     nm, result, e, want, PW);
        end
    endtask

    task automatic test_vectors();
        logic [PW-1:0] p511, ones;
        logic [MW-1:0] m256, p255;
        p511 = {PW{1'b0}};
        p511[PW-1] = 1'b1;
        ones = {PW{1'b1}};
        m256 = {MW{1'b1}};
        p255 = {MW{1'b0}};
        p255[MW-1] = 1'b1;
        run_vec("pow511_mod_m256", p511, m256, p255);
        run_vec("small_lt_n", PW'(5), p255, MW'(5));
        run_vec("ones_mod_1", ones, MW'(1), MW'(0));
        run_vec("ones_mod_m256", ones, m256, MW'(0));
        run_vec("ones_mod_7", ones, MW'(7), MW'(3));
    endtask

    task automatic test_rst_mid();
        int   e;
        logic bp, ba;
        start_op(PW'(100), MW'(7));
        repeat (199) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, result} !== {2'b00, MW'(0)}) begin
            bad++;
            $display("FAIL rst_mid_clear got=%b%b/%0h want=00/0",
                     busy, done, result);
        end
        rst = 1'b0;
        start_op(PW'(100), MW'(7));
        wait_done(e, bp, ba);
        total++;
        if (e !== PW || result !== MW'(2)) begin
            bad++;
            $display("FAIL rst_mid_rerun got=%0d lat=%0d want=2 lat=%0d",
                     result, e, PW);
        end
    endtask

    task automatic test_zero();
        int   e;
        logic bp, ba;
        start_op(PW'(12345), MW'(0));
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_busy_e0 got=%b want=0", busy);
        end
        wait_done(e, bp, ba);
        total++;
        if (e !== 1) begin
            bad++;
            $display("FAIL zero_latency got=%0d want=1", e);
        end
        total++;
        if ({err, result} !== {1'b1, MW'(0)}) begin
            bad++;
            $display("FAIL zero_out got=%b/%0h want=1/0", err, result);
        end
        total++;
        if (ba !== 1'b0) begin
            bad++;
            $display("FAIL zero_busy_seen got=%b want=0", ba);
        end
    endtask

    task automatic test_back_to_back();
        int   rises;
        int   rise_at;
        logic prev;
        rises   = 0;
        rise_at = 0;
        start_op(PW'(100), MW'(7));
        prev = done;
        for (int k = 1; k <= 800; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done && !prev) begin
                rises++;
                rise_at = k;
            end
            prev = done;
            if (k == 99) begin
                update = 1'b1;
                datain = PW'(1000);
                modn   = MW'(13);
            end
            if (k == 699) update = 1'b0;
        end
        total++;
        if (rises !== 1) begin
            bad++;
            $display("FAIL b2b_done_count got=%0d want=1", rises);
        end
        total++;
        if (rise_at !== PW) begin
            bad++;
            $display("FAIL b2b_latency got=%0d want=%0d", rise_at, PW);
        end
        total++;
        if ({done, err, result} !== {2'b10, MW'(2)}) begin
            bad++;
            $display("FAIL b2b_result got=%b%b/%0d want=10/2",
                     done, err, result);
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        update = 1'b0;
        datain = '0;
        modn   = '0;
        total  = 0;
        bad    = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_rst_mid();
        test_back_to_back();
        test_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_reduce512.md
MOD_REDUCE512 -- requirements
Module: mod_reduce512

Interface
REQ-001 SHALL have parameter PW, default 512, meaning the input product width in bits.
REQ-002 SHALL have parameter MW, default 256, meaning the modulus and result width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port update, input, 1 bit: start request; a rising edge starts one reduction.
REQ-006 SHALL have port datain, input, PW bits: unsigned product, normally the 512-bit multiplier result.
REQ-007 SHALL have port modn, input, MW bits: unsigned modulus n.
REQ-008 SHALL have port result, output, MW bits: datain mod n.
REQ-009 SHALL have port done, output, 1 bit: result valid; held high until the next start.
REQ-010 SHALL have port busy, output, 1 bit: reduction in progress.
REQ-011 SHALL have port err, output, 1 bit: modn was zero at the last start.

Function
REQ-012 SHALL register update into update_d every cycle; start SHALL be update=1 and update_d=0 at a rising edge (the capture edge, E0).
REQ-013 SHALL ignore start while busy=1; holding update high SHALL produce exactly one operation.
REQ-014 SHALL at E0 latch datain and modn into internal registers, clear done and err, and clear remainder r (MW+1 bits) to 0.
REQ-015 SHALL at E0 set bit counter to PW-1; datain and modn changes after E0 SHALL NOT affect the operation.
REQ-016 SHALL use FSM states IDLE, RUN, FIN.
REQ-017 SHALL transition IDLE->RUN on start with modn!=0; IDLE->FIN on start with modn==0.
REQ-018 SHALL transition RUN->FIN at the edge processing bit 0; FIN->IDLE unconditionally on the next edge; FIN->RUN is not allowed.
REQ-019 SHALL, in RUN at edges E1..E(PW), process product bit PW-k at edge Ek, MSB first: t = {r, bit}; r <= (t >= n) ? t - n : t.
REQ-020 SHALL maintain r < n after every step; a single conditional subtraction per step SHALL suffice, with compare and subtract done at MW+1 bits without truncation.
REQ-021 SHALL at edge E(PW) (E512 at defaults) write result <= final r[MW-1:0] and set done=1; latency SHALL be exactly PW edges after capture.
REQ-022 SHALL drive busy=1 from after E0 until after E(PW-1), and busy=0 after E(PW).
REQ-023 SHALL, for the modn==0 case, set err=1, result=0, done=1 at E1, with busy=0 throughout.
REQ-024 SHALL hold result, done and err stable from completion until the next capture edge; result is not cleared at start.
REQ-025 SHALL, when modn==1, give result=0 with normal latency.
REQ-026 SHALL, when datain < n, give result=datain[MW-1:0] with normal latency.

Reset
REQ-027 SHALL, with rst=1 at a rising edge, force state=IDLE, result=0, done=0, busy=0, err=0, r=0, counter=0, update_d=0, regardless of any operation in progress.
REQ-028 SHALL make rst take priority over start when both occur at the same edge.
REQ-029 SHALL, after rst deasserts, start a new operation on the first rising edge of update; if update is already high when rst is released, that SHALL count as a rising edge.

Verification
REQ-030 SHALL cover: datain=100, modn=7 -> result=2, done=1 exactly 512 edges after capture, err=0.
REQ-031 SHALL cover: datain=2^511, modn=2^256-1 -> result=2^255.
REQ-032 SHALL cover: datain=5, modn=2^255 -> result=5; and datain=all-ones, modn=1 -> result=0.
REQ-033 SHALL cover: modn=0, any datain -> err=1, result=0, done=1 one edge after capture, busy never 1.
REQ-034 SHALL cover: rst pulse at E200 of an operation -> busy=0, done=0, result=0 next cycle; a following update edge with datain=100, modn=7 -> result=2 after 512 edges.
REQ-035 SHALL cover: a second update edge at E100 with different operands, and update held high for 600 cycles -> both ignored; exactly one done assertion with the first operands' result.
